bmc_acs_sched: RTL and testbench

//  Sequencer for the shared BMC/ACS butterfly array of the rate-1/2, 64-state Viterbi decoder.
//  - Accepts one received symbol pair per trellis step over a valid/ready handshake.
//  - Holds the pair stable on the BMC inputs and walks the ACS array through NUM_STATES/PAR state groups.
//  - Ping-pongs the path-metric bank and schedules metric normalisation.
//  - Generates survivor-memory write addresses for traceback.

---
 rtl/viterbi_pkg.sv | 20 ++
 rtl/bmc_acs_step_ctr.sv | 28 ++
 rtl/bmc_acs_sched.sv | 140 ++++++++++++++
 tb/tb_bmc_acs_sched.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants and types for the Viterbi decoder control blocks.
// Holds default trellis dimensions, width helpers and the scheduler FSM encoding.
package viterbi_pkg;

    localparam int VIT_NUM_STATES = 64;
    localparam int VIT_PAR        = 8;
    localparam int VIT_TB_DEPTH   = 32;

    // A 1-group trellis still needs a 1-bit group index.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SWAP = 2'd2
    } sched_state_t;

endpackage

// File: rtl/bmc_acs_step_ctr.sv
// Group counter for one trellis step: counts 0..G-1 while enabled and flags the last group.
// Also usable by the traceback controller to walk survivor groups.
module bmc_acs_step_ctr #(
    parameter int G  = 8,
    parameter int GW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [GW-1:0] o_cnt,
    output logic          o_last
);

    logic [GW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == GW'(G - 1));

endmodule

// File: rtl/bmc_acs_sched.sv
// Sequencer for the shared BMC/ACS butterfly array: accepts one symbol pair per trellis step,
// walks the ACS groups, ping-pongs the metric bank, schedules normalisation and survivor addresses.
module bmc_acs_sched
    import viterbi_pkg::*;
#(
    parameter int  NUM_STATES = VIT_NUM_STATES,
    parameter int  PAR        = VIT_PAR,
    parameter int  TB_DEPTH   = VIT_TB_DEPTH,
    localparam int G          = NUM_STATES / PAR,
    localparam int GW         = clog2_min1(G),
    localparam int AW         = $clog2(TB_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [1:0]    rx_pair,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [1:0]    bmc_rx_pair,
    output logic          acs_en,
    output logic [GW-1:0] acs_grp,
    output logic          acs_norm,
    input  logic          acs_ovf,
    output logic          bank_sel,
    output logic          tb_wr_en,
    output logic [AW-1:0] tb_addr,
    output logic          step_done,
    output logic [1:0]    o_dbg_state
);

    // Handshake: a pair transfers on a rising edge where rx_valid and rx_ready are both high.
    // rx_ready depends only on the FSM state, so rx_pair may change freely while it is low.

    sched_state_t  r_state;
    sched_state_t  w_state_nxt;
    logic [1:0]    r_bmc_rx_pair;
    logic          r_bank_sel;
    logic [AW-1:0] r_tb_addr;
    logic          r_acs_norm;
    logic          r_ovf_seen;

    logic          w_rx_ready;
    logic          w_acs_en;
    logic          w_step_done;
    logic          w_accept;
    logic          w_soft_clr;
    logic [GW-1:0] w_grp;
    logic          w_grp_last;

    bmc_acs_step_ctr #(
        .G  (G),
        .GW (GW)
    ) u_step_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (~w_acs_en),
        .i_en   (w_acs_en),
        .o_cnt  (w_grp),
        .o_last (w_grp_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (rx_valid)   w_state_nxt = ST_RUN;
            ST_RUN:  if (w_grp_last) w_state_nxt = ST_SWAP;
            ST_SWAP: w_state_nxt = rx_valid ? ST_RUN : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rx_ready  = 1'b0;
        w_acs_en    = 1'b0;
        w_step_done = 1'b0;
        unique case (r_state)
            ST_IDLE: w_rx_ready = 1'b1;
            ST_RUN:  w_acs_en   = 1'b1;
            ST_SWAP: begin
                w_rx_ready  = 1'b1;
                w_step_done = 1'b1;
            end
            default: w_rx_ready = 1'b0;
        endcase
    end

    assign w_accept   = w_rx_ready & rx_valid;
    // A pending pair wins over a soft clear in IDLE; clr is ignored elsewhere.
    assign w_soft_clr = (r_state == ST_IDLE) & ~rx_valid & clr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bmc_rx_pair <= 2'b00;
            r_bank_sel    <= 1'b0;
            r_tb_addr     <= '0;
            r_acs_norm    <= 1'b0;
            r_ovf_seen    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_bmc_rx_pair <= rx_pair;
            end
            if (w_soft_clr) begin
                r_bank_sel <= 1'b0;
                r_tb_addr  <= '0;
                r_acs_norm <= 1'b0;
                r_ovf_seen <= 1'b0;
            end
            if (w_acs_en) begin
                r_ovf_seen <= r_ovf_seen | acs_ovf;
            end
            // The last group's overflow is already folded into r_ovf_seen on the way into SWAP.
            if (w_step_done) begin
                r_bank_sel <= ~r_bank_sel;
                r_tb_addr  <= r_tb_addr + 1'b1;
                r_acs_norm <= r_ovf_seen;
                r_ovf_seen <= 1'b0;
            end
        end
    end

    assign rx_ready    = w_rx_ready;
    assign bmc_rx_pair = r_bmc_rx_pair;
    assign acs_en      = w_acs_en;
    assign acs_grp     = w_acs_en ? w_grp : '0;
    assign acs_norm    = r_acs_norm;
    assign bank_sel    = r_bank_sel;
    assign tb_wr_en    = w_acs_en;
    assign tb_addr     = r_tb_addr;
    assign step_done   = w_step_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bmc_acs_sched.sv
// Self-checking bench for bmc_acs_sched: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a step-position reference model.
module tb_bmc_acs_sched;

    localparam int G   = 8;
    localparam int TBD = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic [1:0] rx_pair;
    logic       rx_valid;
    logic       rx_ready;
    logic [1:0] bmc_rx_pair;
    logic       acs_en;
    logic [2:0] acs_grp;
    logic       acs_norm;
    logic       acs_ovf;
    logic       bank_sel;
    logic       tb_wr_en;
    logic [4:0] tb_addr;
    logic       step_done;
    logic [1:0] dbg_state;

    bmc_acs_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .rx_pair     (rx_pair),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .bmc_rx_pair (bmc_rx_pair),
        .acs_en      (acs_en),
        .acs_grp     (acs_grp),
        .acs_norm    (acs_norm),
        .acs_ovf     (acs_ovf),
        .bank_sel    (bank_sel),
        .tb_wr_en    (tb_wr_en),
        .tb_addr     (tb_addr),
        .step_done   (step_done),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int e_addr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within a step (-1 idle, 0..G-1 group, G bank swap).
    bit         m_live = 1'b0;
    int         m_pos  = -1;
    logic [1:0] m_pair = 2'b00;
    bit         m_bank = 1'b0;
    int         m_addr = 0;
    bit         m_norm = 1'b0;
    bit         m_ovf  = 1'b0;

    always @(posedge clk) begin : model
        int         p;
        int         addr;
        bit         ready;
        bit         ovf;
        bit         bank;
        bit         norm;
        logic [1:0] pair;
        if (!rst_n) begin
            m_live <= 1'b1;
            m_pos  <= -1;
            m_pair <= 2'b00;
            m_bank <= 1'b0;
            m_addr <= 0;
            m_norm <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (m_live) begin
            p     = m_pos;
            addr  = m_addr;
            ovf   = m_ovf;
            bank  = m_bank;
            norm  = m_norm;
            pair  = m_pair;
            ready = (p == -1) || (p == G);
            if (p >= 0 && p < G) ovf = ovf | acs_ovf;
            if (p == G) begin
                bank = !bank;
                addr = (addr + 1) % TBD;
                norm = ovf;
                ovf  = 1'b0;
            end
            if (ready && rx_valid) begin
                pair = rx_pair;
                p    = 0;
            end else if (p == -1) begin
                if (clr) begin
                    addr = 0;
                    bank = 1'b0;
                    norm = 1'b0;
                    ovf  = 1'b0;
                end
            end else if (p == G) begin
                p = -1;
            end else begin
                p = p + 1;
            end
            m_pos  <= p;
            m_addr <= addr;
            m_ovf  <= ovf;
            m_bank <= bank;
            m_norm <= norm;
            m_pair <= pair;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("m_rx_ready",  rx_ready,    (m_pos == -1) || (m_pos == G));
            chk("m_acs_en",    acs_en,      (m_pos >= 0) && (m_pos < G));
            chk("m_tb_wr_en",  tb_wr_en,    (m_pos >= 0) && (m_pos < G));
            chk("m_acs_grp",   acs_grp,     (m_pos >= 0 && m_pos < G) ? m_pos : 0);
            chk("m_step_done", step_done,   m_pos == G);
            chk("m_bmc_pair",  bmc_rx_pair, m_pair);
            chk("m_bank_sel",  bank_sel,    m_bank);
            chk("m_tb_addr",   tb_addr,     m_addr);
            chk("m_acs_norm",  acs_norm,    m_norm);
        end
    end

    task automatic run_step(input logic [1:0] p, input int ovf_grp, input bit exp_norm);
        @(negedge clk);
        chk("idle_addr", tb_addr, e_addr);
        rx_valid = 1'b1;
        rx_pair  = p;
        for (int i = 0; i < G; i++) begin
            @(negedge clk);
            if (i == 0) begin
                rx_valid = 1'b0;
                rx_pair  = ~p;
            end
            chk("run_grp", acs_grp, i);
            chk("run_en", acs_en, 1'b1);
            chk("run_pair", bmc_rx_pair, p);
            chk("run_norm", acs_norm, exp_norm);
            acs_ovf = (i == ovf_grp);
        end
        @(negedge clk);
        chk("step_done", step_done, 1'b1);
        acs_ovf = 1'b0;
        e_addr  = (e_addr + 1) % TBD;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_addr", tb_addr, 0);
        chk("clr_bank", bank_sel, 1'b0);
        e_addr = 0;
    endtask

    logic [1:0] b2b_pairs [3];

    initial begin
        int acc;
        int last_done;
        int dones;
        bit hit;
        b2b_pairs[0] = 2'b00;
        b2b_pairs[1] = 2'b01;
        b2b_pairs[2] = 2'b11;
        rst_n    = 1'b0;
        clr      = 1'b0;
        rx_valid = 1'b1;
        rx_pair  = 2'b11;
        acs_ovf  = 1'b0;

        // reset held three edges with rx_valid high
        repeat (3) @(negedge clk);
        chk("rst_ready", rx_ready, 1'b1);
        chk("rst_acs_en", acs_en, 1'b0);
        chk("rst_addr", tb_addr, 0);
        chk("rst_bank", bank_sel, 1'b0);
        chk("rst_pair", bmc_rx_pair, 2'b00);
        rst_n    = 1'b1;
        rx_valid = 1'b0;

        // single step
        run_step(2'b10, -1, 1'b0);
        @(negedge clk);
        chk("single_done_low", step_done, 1'b0);
        chk("single_bank", bank_sel, 1'b1);
        chk("single_addr", tb_addr, 1);

        // back-to-back with rx_valid held high
        do_clr();
        rx_valid  = 1'b1;
        rx_pair   = b2b_pairs[0];
        acc       = 1;
        dones     = 0;
        last_done = 0;
        for (int c = 0; c < 60 && dones < 3; c++) begin
            @(negedge clk);
            if (step_done) begin
                if (dones > 0) chk("b2b_gap", c - last_done, G + 1);
                last_done = c;
                dones++;
                if (acc < 3) begin
                    rx_pair = b2b_pairs[acc];
                    acc++;
                end else begin
                    rx_valid = 1'b0;
                end
            end else if (acs_en) begin
                chk("b2b_bank", bank_sel, dones % 2);
                chk("b2b_pair", bmc_rx_pair, b2b_pairs[dones]);
            end
        end
        chk("b2b_steps", dones, 3);
        rx_valid = 1'b0;
        e_addr   = 3;

        // normalisation: overflow in group 5 of step k
        run_step(2'b01, 5, 1'b0);
        run_step(2'b10, -1, 1'b1);
        run_step(2'b11, -1, 1'b0);

        // survivor address wrap, then clear from IDLE
        do_clr();
        for (int s = 0; s < TBD; s++) run_step(2'($urandom_range(0, 3)), -1, 1'b0);
        @(negedge clk);
        chk("wrap_addr", tb_addr, 0);
        for (int s = 0; s < 3; s++) run_step(2'($urandom_range(0, 3)), -1, 1'b0);
        do_clr();

        // reset in the middle of a step
        run_step(2'b01, -1, 1'b0);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_pair  = 2'b10;
        hit      = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            if (acs_en && acs_grp == 3'd4) begin
                rst_n = 1'b0;
                hit   = 1'b1;
                break;
            end
        end
        chk("midrst_reached", hit, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_en", acs_en, 1'b0);
        chk("midrst_ready", rx_ready, 1'b1);
        chk("midrst_bank", bank_sel, 1'b0);
        chk("midrst_addr", tb_addr, 0);
        chk("midrst_done", step_done, 1'b0);
        e_addr = 0;
        run_step(2'b11, -1, 1'b0);
        @(negedge clk);
        chk("post_rst_bank", bank_sel, 1'b1);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_n    = ($urandom_range(0, 299) != 0);
            rx_valid = ($urandom_range(0, 3) != 0);
            rx_pair  = 2'($urandom_range(0, 3));
            clr      = ($urandom_range(0, 7) == 0);
            acs_ovf  = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        clr      = 1'b0;
        rx_valid = 1'b0;
        acs_ovf  = 1'b0;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
